pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl -- game sequencing for a two-player pong.
//
// Walks IDLE -> SERVE -> PLAY -> POINT/OVER, keeps both scores, and gates
// ball motion. All timing inside SERVE and POINT is counted in video frames
// (frame_tick), never in pixel clocks.
//
// Ports
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse per video frame
//   start_btn             synchronised start level (rising edge detected here)
//   pause_sw              pause level, effective in SERVE/PLAY/POINT
//   left_miss/right_miss  one-cycle pulses, ball passed the left/right paddle
//   ball_run              ball motion enable
//   serve_load            one-cycle pulse on every SERVE entry (ball to centre)
//   serve_dir             0 = serve to the right, 1 = serve to the left
//   score_left/right      point counts
//   game_over, winner     OVER flag; winner 0 = left, 1 = right
//   state                 IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_sw,
    input  logic       left_miss,
    input  logic       right_miss,
    output logic       ball_run,
    output logic       serve_load,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN      = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LD = 8'(POINT_FRAMES - 1);

    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       armed_q, armed_d;
    logic       ball_run_q, ball_run_d;
    logic       serve_load_q, serve_load_d;
    logic       serve_dir_q, serve_dir_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       start_prev_q;

    logic       start_edge;
    logic       frame_step;
    logic       frame_expired;
    logic [3:0] score_l_inc, score_r_inc;

    assign start_edge  = start_btn & ~start_prev_q;
    // Pause freezes the whole frame counter, arming flag included.
    assign frame_step  = frame_tick & ~pause_sw;
    // The first tick after a state entry only aligns us to a frame boundary
    // (armed_q), so a SERVE/POINT phase spans FRAMES+1 ticks.
    assign frame_expired = frame_step & armed_q & (frame_cnt_q == 8'd0);
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        armed_d      = armed_q;
        serve_load_d = 1'b0;
        serve_dir_d  = serve_dir_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    score_l_d    = 4'd0;
                    score_r_d    = 4'd0;
                    serve_dir_d  = 1'b0;
                    game_over_d  = 1'b0;
                    winner_d     = 1'b0;
                    frame_cnt_d  = SERVE_LD;
                    armed_d      = 1'b0;
                    serve_load_d = 1'b1;
                    state_d      = S_SERVE;
                end
            end
            S_SERVE, S_POINT: begin
                if (frame_expired) begin
                    if (state_q == S_SERVE) begin
                        state_d = S_PLAY;
                    end else begin
                        frame_cnt_d  = SERVE_LD;
                        armed_d      = 1'b0;
                        serve_load_d = 1'b1;
                        state_d      = S_SERVE;
                    end
                end else if (frame_step) begin
                    if (!armed_q) armed_d = 1'b1;
                    else          frame_cnt_d = frame_cnt_q - 8'd1;
                end
            end
            S_PLAY: begin
                // Simultaneous misses cancel; paused misses are dropped.
                if (!pause_sw && (left_miss ^ right_miss)) begin
                    frame_cnt_d = POINT_LD;
                    armed_d     = 1'b0;
                    state_d     = S_POINT;
                    if (left_miss) begin
                        score_r_d   = score_r_inc;
                        serve_dir_d = 1'b1;
                        if (score_r_inc == WIN) begin
                            state_d     = S_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                        end
                    end else begin
                        score_l_d   = score_l_inc;
                        serve_dir_d = 1'b0;
                        if (score_l_inc == WIN) begin
                            state_d     = S_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ball_run_d = (state_d == S_PLAY) && !pause_sw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= 8'd0;
            armed_q      <= 1'b0;
            ball_run_q   <= 1'b0;
            serve_load_q <= 1'b0;
            serve_dir_q  <= 1'b0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
            // A button held through reset must not look like a fresh press.
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            armed_q      <= armed_d;
            ball_run_q   <= ball_run_d;
            serve_load_q <= serve_load_d;
            serve_dir_q  <= serve_dir_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            start_prev_q <= start_btn;
        end
    end

    assign ball_run    = ball_run_q;
    assign serve_load  = serve_load_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule
